// File: rtl/router_pkg.sv
// router_pkg: shared definitions for the router datapath register slice.
//   DEF_WIDTH / DEF_ADDR_W : default byte and address-field widths
//   addr_e                 : destination address encodings (3 is invalid)
//   ADDR_LSB / LEN_LSB     : header field positions, header = {len, addr}
package router_pkg;

    localparam int unsigned DEF_WIDTH  = 8;
    localparam int unsigned DEF_ADDR_W = 2;

    typedef enum logic [1:0] {
        ADDR0        = 2'd0,
        ADDR1        = 2'd1,
        ADDR2        = 2'd2,
        ADDR_INVALID = 2'd3
    } addr_e;

    localparam int unsigned ADDR_LSB = 0;
    localparam int unsigned LEN_LSB  = 2;

endpackage

// File: rtl/router_parity_chk.sv
// router_parity_chk: running parity of the packet and comparison against the
// parity byte sent by the source.
//   clock, resetn          : clock and synchronous active-low reset
//   detect_add             : new packet starting, clears parity and err
//   lfd_state, ld_state    : header / payload load states from router_fsm
//   pkt_valid, data_in     : source handshake and byte
//   header_byte            : captured header, folded in during lfd_state
//   parity_done            : parity byte captured, enables the comparison
//   err                    : sticky parity mismatch for the current packet
module router_parity_chk
    import router_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             detect_add,
    input  logic             lfd_state,
    input  logic             ld_state,
    input  logic             pkt_valid,
    input  logic [WIDTH-1:0] data_in,
    input  logic [WIDTH-1:0] header_byte,
    input  logic             parity_done,
    output logic             err
);

    logic [WIDTH-1:0] internal_parity_d, internal_parity_q;
    logic [WIDTH-1:0] packet_parity_d, packet_parity_q;
    logic             err_d, err_q;

    always_comb begin
        internal_parity_d = internal_parity_q;
        packet_parity_d   = packet_parity_q;
        err_d             = err_q;

        // Bytes diverted to the hold register in LOAD_DATA are counted here;
        // their later replay in LOAD_AFTER_FULL is not.
        if (detect_add)
            internal_parity_d = '0;
        else if (lfd_state)
            internal_parity_d = internal_parity_q ^ header_byte;
        else if (ld_state && pkt_valid)
            internal_parity_d = internal_parity_q ^ data_in;

        if (ld_state && !pkt_valid)
            packet_parity_d = data_in;

        // parity_done is still high in the DECODE_ADDRESS cycle of the next
        // packet, so the clear must win or a stale mismatch would re-arm err.
        if (detect_add)
            err_d = 1'b0;
        else if (parity_done && (internal_parity_q != packet_parity_q))
            err_d = 1'b1;
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            internal_parity_q <= '0;
            packet_parity_q   <= '0;
            err_q             <= 1'b0;
        end else begin
            internal_parity_q <= internal_parity_d;
            packet_parity_q   <= packet_parity_d;
            err_q             <= err_d;
        end
    end

    assign err = err_q;

endmodule

// File: rtl/router_reg.sv
// router_reg: datapath register stage of the 1:3 router, between the packet
// source and the output FIFOs, sequenced by router_fsm.
//   clock, resetn          : clock and synchronous active-low reset
//   pkt_valid, data_in     : source byte valid (low on parity byte) and byte
//   fifo_full              : selected output FIFO full
//   detect_add .. rst_int_reg : one-hot state indications from router_fsm
//   dout                   : byte presented to the FIFO write port
//   parity_done            : parity byte captured
//   low_pkt_valid          : pkt_valid seen low during LOAD_DATA
//   err                    : parity mismatch for the current packet
module router_reg
    import router_pkg::*;
#(
    parameter int unsigned WIDTH  = DEF_WIDTH,
    parameter int unsigned ADDR_W = DEF_ADDR_W
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             pkt_valid,
    input  logic [WIDTH-1:0] data_in,
    input  logic             fifo_full,
    input  logic             detect_add,
    input  logic             lfd_state,
    input  logic             ld_state,
    input  logic             laf_state,
    input  logic             full_state,
    input  logic             rst_int_reg,
    output logic [WIDTH-1:0] dout,
    output logic             parity_done,
    output logic             low_pkt_valid,
    output logic             err
);

    logic [WIDTH-1:0] dout_d, dout_q;
    logic [WIDTH-1:0] header_byte_d, header_byte_q;
    logic [WIDTH-1:0] hold_byte_d, hold_byte_q;
    logic             parity_done_d, parity_done_q;
    logic             low_pkt_valid_d, low_pkt_valid_q;
    logic             addr_ok;

    assign addr_ok = (data_in[ADDR_LSB +: ADDR_W] != ADDR_W'(ADDR_INVALID));

    always_comb begin
        dout_d          = dout_q;
        header_byte_d   = header_byte_q;
        hold_byte_d     = hold_byte_q;
        parity_done_d   = parity_done_q;
        low_pkt_valid_d = low_pkt_valid_q;

        if (detect_add && pkt_valid && addr_ok)
            header_byte_d = data_in;

        // full_state falls through to the hold default on purpose.
        if (lfd_state)
            dout_d = header_byte_q;
        else if (ld_state && !fifo_full)
            dout_d = data_in;
        else if (ld_state && fifo_full)
            hold_byte_d = data_in;
        else if (laf_state)
            dout_d = hold_byte_q;

        if (rst_int_reg)
            low_pkt_valid_d = 1'b0;
        else if (ld_state && !pkt_valid)
            low_pkt_valid_d = 1'b1;

        if ((ld_state && !pkt_valid && !fifo_full) ||
            (laf_state && low_pkt_valid_q && !parity_done_q))
            parity_done_d = 1'b1;
        else if (detect_add)
            parity_done_d = 1'b0;
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            dout_q          <= '0;
            header_byte_q   <= '0;
            hold_byte_q     <= '0;
            parity_done_q   <= 1'b0;
            low_pkt_valid_q <= 1'b0;
        end else begin
            dout_q          <= dout_d;
            header_byte_q   <= header_byte_d;
            hold_byte_q     <= hold_byte_d;
            parity_done_q   <= parity_done_d;
            low_pkt_valid_q <= low_pkt_valid_d;
        end
    end

    router_parity_chk #(
        .WIDTH(WIDTH)
    ) u_parity_chk (
        .clock      (clock),
        .resetn     (resetn),
        .detect_add (detect_add),
        .lfd_state  (lfd_state),
        .ld_state   (ld_state),
        .pkt_valid  (pkt_valid),
        .data_in    (data_in),
        .header_byte(header_byte_q),
        .parity_done(parity_done_q),
        .err        (err)
    );

    assign dout          = dout_q;
    assign parity_done   = parity_done_q;
    assign low_pkt_valid = low_pkt_valid_q;

endmodule

// File: tb/tb_router_reg.sv
// tb_router_reg: directed scoreboard bench for router_reg. Each stimulus cycle
// pushes the outputs expected after the next rising edge; they are popped and
// compared #1 after that edge.
module tb_router_reg;

    localparam int SEL_DOUT = 0;
    localparam int SEL_ERR  = 1;
    localparam int SEL_PD   = 2;
    localparam int SEL_LPV  = 3;

    typedef struct {
        string      tag;
        int         sel;
        logic [7:0] val;
    } exp_t;

    logic       clock = 1'b0;
    logic       resetn;
    logic       pkt_valid;
    logic [7:0] data_in;
    logic       fifo_full;
    logic       detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg;
    logic [7:0] dout;
    logic       parity_done, low_pkt_valid, err;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    router_reg #(
        .WIDTH (8),
        .ADDR_W(2)
    ) dut (
        .clock        (clock),
        .resetn       (resetn),
        .pkt_valid    (pkt_valid),
        .data_in      (data_in),
        .fifo_full    (fifo_full),
        .detect_add   (detect_add),
        .lfd_state    (lfd_state),
        .ld_state     (ld_state),
        .laf_state    (laf_state),
        .full_state   (full_state),
        .rst_int_reg  (rst_int_reg),
        .dout         (dout),
        .parity_done  (parity_done),
        .low_pkt_valid(low_pkt_valid),
        .err          (err)
    );

    always #5 clock = ~clock;

    task automatic check_val(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %02h expected %02h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] observe(input int sel);
        case (sel)
            SEL_DOUT: return dout;
            SEL_ERR:  return {7'd0, err};
            SEL_PD:   return {7'd0, parity_done};
            default:  return {7'd0, low_pkt_valid};
        endcase
    endfunction

    // state: one of "DA","LFD","LD","LAF","FULL","RST","IDLE"
    task automatic drive(input string st, input logic pv, input logic [7:0] d,
                         input logic ff);
        detect_add  = (st == "DA");
        lfd_state   = (st == "LFD");
        ld_state    = (st == "LD");
        laf_state   = (st == "LAF");
        full_state  = (st == "FULL");
        rst_int_reg = (st == "RST");
        pkt_valid   = pv;
        data_in     = d;
        fifo_full   = ff;
    endtask

    task automatic push(input string tag, input int sel, input logic [7:0] val);
        exp_t e;
        e.tag = tag;
        e.sel = sel;
        e.val = val;
        exp_q.push_back(e);
    endtask

    task automatic tick();
        exp_t e;
        @(posedge clock);
        #1;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check_val(e.tag, observe(e.sel), e.val);
        end
    endtask

    initial begin
        resetn = 1'b0;
        drive("IDLE", 1'b0, 8'h00, 1'b0);

        // Reset state
        push("rst_dout", SEL_DOUT, 8'h00); push("rst_err", SEL_ERR, 8'h00);
        push("rst_pd", SEL_PD, 8'h00);     push("rst_lpv", SEL_LPV, 8'h00);
        tick();
        resetn = 1'b1;

        // Good packet 0D / 01 02 03 / parity 0D
        drive("DA", 1'b1, 8'h0D, 1'b0);  push("g_da_pd", SEL_PD, 8'h00); tick();
        drive("LFD", 1'b1, 8'h01, 1'b0); push("g_lfd_dout", SEL_DOUT, 8'h0D); tick();
        drive("LD", 1'b1, 8'h01, 1'b0);  push("g_ld1", SEL_DOUT, 8'h01); tick();
        drive("LD", 1'b1, 8'h02, 1'b0);  push("g_ld2", SEL_DOUT, 8'h02); tick();
        drive("LD", 1'b1, 8'h03, 1'b0);  push("g_ld3", SEL_DOUT, 8'h03);
        push("g_pd_early", SEL_PD, 8'h00); tick();
        drive("LD", 1'b0, 8'h0D, 1'b0);  push("g_par_dout", SEL_DOUT, 8'h0D);
        push("g_pd", SEL_PD, 8'h01); push("g_lpv", SEL_LPV, 8'h01); tick();
        drive("RST", 1'b1, 8'h00, 1'b0); push("g_err", SEL_ERR, 8'h00);
        push("g_lpv_clr", SEL_LPV, 8'h00); tick();
        drive("IDLE", 1'b1, 8'h00, 1'b0); push("g_err_idle", SEL_ERR, 8'h00); tick();

        // Bad parity packet: parity 0E
        drive("DA", 1'b1, 8'h0D, 1'b0);  tick();
        drive("LFD", 1'b1, 8'h01, 1'b0); tick();
        drive("LD", 1'b1, 8'h01, 1'b0);  tick();
        drive("LD", 1'b1, 8'h02, 1'b0);  tick();
        drive("LD", 1'b1, 8'h03, 1'b0);  tick();
        drive("LD", 1'b0, 8'h0E, 1'b0);  push("b_pd", SEL_PD, 8'h01);
        push("b_err_early", SEL_ERR, 8'h00); tick();
        drive("RST", 1'b1, 8'h00, 1'b0); push("b_err", SEL_ERR, 8'h01); tick();
        drive("IDLE", 1'b1, 8'h00, 1'b0); push("b_err_sticky", SEL_ERR, 8'h01); tick();
        drive("DA", 1'b1, 8'h0D, 1'b0);  push("b_err_clr", SEL_ERR, 8'h00);
        push("b_pd_clr", SEL_PD, 8'h00); tick();

        // fifo_full on payload 02
        drive("LFD", 1'b1, 8'h01, 1'b0); push("f_lfd", SEL_DOUT, 8'h0D); tick();
        drive("LD", 1'b1, 8'h01, 1'b0);  push("f_ld1", SEL_DOUT, 8'h01); tick();
        drive("LD", 1'b1, 8'h02, 1'b1);  push("f_hold", SEL_DOUT, 8'h01); tick();
        drive("FULL", 1'b1, 8'h03, 1'b1); push("f_full", SEL_DOUT, 8'h01); tick();
        drive("LAF", 1'b1, 8'h03, 1'b0); push("f_laf", SEL_DOUT, 8'h02);
        push("f_laf_pd", SEL_PD, 8'h00); tick();
        drive("LD", 1'b1, 8'h03, 1'b0);  push("f_ld3", SEL_DOUT, 8'h03); tick();
        drive("LD", 1'b0, 8'h0D, 1'b0);  push("f_par", SEL_DOUT, 8'h0D);
        push("f_pd", SEL_PD, 8'h01); tick();
        drive("RST", 1'b1, 8'h00, 1'b0); push("f_err", SEL_ERR, 8'h00); tick();

        // fifo_full on the parity byte
        drive("DA", 1'b1, 8'h0D, 1'b0);  tick();
        drive("LFD", 1'b1, 8'h01, 1'b0); tick();
        drive("LD", 1'b1, 8'h01, 1'b0);  tick();
        drive("LD", 1'b1, 8'h02, 1'b0);  tick();
        drive("LD", 1'b1, 8'h03, 1'b0);  tick();
        drive("LD", 1'b0, 8'h0D, 1'b1);  push("p_lpv", SEL_LPV, 8'h01);
        push("p_pd", SEL_PD, 8'h00); push("p_dout", SEL_DOUT, 8'h03); tick();
        drive("FULL", 1'b0, 8'h00, 1'b1); push("p_full_pd", SEL_PD, 8'h00); tick();
        drive("LAF", 1'b0, 8'h00, 1'b0); push("p_laf_dout", SEL_DOUT, 8'h0D);
        push("p_laf_pd", SEL_PD, 8'h01); tick();
        drive("RST", 1'b1, 8'h00, 1'b0); push("p_lpv_clr", SEL_LPV, 8'h00);
        push("p_err", SEL_ERR, 8'h00); tick();

        // Address 3 header ignored: lfd still replays 0D
        drive("DA", 1'b1, 8'h07, 1'b0);  push("a3_pd", SEL_PD, 8'h00); tick();
        drive("LFD", 1'b1, 8'h01, 1'b0); push("a3_dout", SEL_DOUT, 8'h0D); tick();

        // Reset mid-payload
        drive("DA", 1'b1, 8'h0D, 1'b0);  tick();
        drive("LFD", 1'b1, 8'h01, 1'b0); tick();
        drive("LD", 1'b1, 8'h01, 1'b0);  tick();
        drive("LD", 1'b1, 8'h02, 1'b0);  push("r_pre", SEL_DOUT, 8'h02); tick();
        resetn = 1'b0;
        drive("LD", 1'b1, 8'h03, 1'b0);  push("r_dout", SEL_DOUT, 8'h00);
        push("r_err", SEL_ERR, 8'h00); push("r_pd", SEL_PD, 8'h00);
        push("r_lpv", SEL_LPV, 8'h00); tick();

        // Reset beats a parity byte in the same cycle
        resetn = 1'b1;
        drive("DA", 1'b1, 8'h0D, 1'b0);  tick();
        drive("LFD", 1'b1, 8'h01, 1'b0); push("r2_lfd", SEL_DOUT, 8'h0D); tick();
        resetn = 1'b0;
        drive("LD", 1'b0, 8'h0D, 1'b0);  push("r2_dout", SEL_DOUT, 8'h00);
        push("r2_pd", SEL_PD, 8'h00); push("r2_lpv", SEL_LPV, 8'h00); tick();
        resetn = 1'b1;
        drive("IDLE", 1'b0, 8'h00, 1'b0); tick();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
